// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
// Holds the receiver state encoding, parity mode constants and the default
// bit period used by uart_rx_fifo.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 2603;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head output
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write strobe and word; dropped when full unless a pop
//                       happens in the same cycle
//   pop                 read strobe; ignored when empty
//   head_data           word at the head (valid only when !empty)
//   full, empty, count  occupancy status
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO still
  // accepts a push when it is being read.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver feeding a small receive FIFO
// Ports:
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   i_rx                 asynchronous serial input, idle high
//   o_data, o_parity_err, o_frame_err   head word and its error flags
//   o_valid, i_ready     FIFO not empty / pop strobe
//   o_count              FIFO occupancy
//   o_overrun, i_clear_err  sticky dropped-word flag and its clear
//   o_busy               receiver is inside a frame
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_EVEN,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_rx,
  output logic [DATA_BITS-1:0]          o_data,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overrun,
  input  logic                          i_clear_err,
  output logic                          o_busy
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int BW    = $clog2(DATA_BITS);
  localparam int WIDTH = DATA_BITS + 2;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  rx_state_t state, state_n;

  logic                 sync1, sync2, prev_rx, rx;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 tick;
  logic                 push;
  logic [WIDTH-1:0]     push_word;
  logic [WIDTH-1:0]     head_word;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign rx   = sync2;
  assign tick = (cnt == BIT_LAST);

  // Synchroniser and edge history reset high so that releasing reset with
  // the line idle never looks like a start edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      prev_rx <= 1'b1;
    end else begin
      sync1   <= i_rx;
      sync2   <= sync1;
      prev_rx <= rx;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (prev_rx && !rx) state_n = ST_START;
      end
      ST_START: begin
        // Mid-bit check: a line already back high was only a glitch.
        if (cnt == HALF_LAST) state_n = rx ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick && bit_idx == DATA_LAST)
          state_n = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (tick) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (tick && stop_idx == STOP_LAST) begin
          push    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The bit counter restarts on every state change and every sample, so
  // successive samples stay exactly one bit period apart.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (state == ST_IDLE || state_n != state || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          perr_q   <= 1'b0;
          ferr_q   <= 1'b0;
        end
        ST_DATA: begin
          if (tick) begin
            // Shift in at the MSB so the first bit ends up in bit 0.
            shreg   <= {rx, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BW'(1);
          end
        end
        ST_PARITY: begin
          if (tick) perr_q <= (^shreg) ^ rx ^ (PARITY == PARITY_ODD);
        end
        ST_STOP: begin
          if (tick) begin
            ferr_q   <= ferr_q | ~rx;
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The final stop sample is folded in directly since it is pushed on the
  // same edge it is taken.
  assign push_word = {shreg, perr_q, ferr_q | ~rx};

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .push      (push),
    .push_data (push_word),
    .pop       (i_ready),
    .head_data (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_count)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_overrun <= 1'b0;
    end else if (push && fifo_full && !(i_ready && !fifo_empty)) begin
      o_overrun <= 1'b1;
    end else if (i_clear_err) begin
      o_overrun <= 1'b0;
    end
  end

  assign o_data       = head_word[WIDTH-1:2];
  assign o_parity_err = head_word[1];
  assign o_frame_err  = head_word[0];
  assign o_valid      = !fifo_empty;
  assign o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       ready = 1'b0;
  logic       ready_odd = 1'b1;
  logic       clear_err = 1'b0;

  logic [7:0] data, data_odd;
  logic       perr, ferr, perr_odd, ferr_odd;
  logic       valid, valid_odd;
  logic [2:0] count, count_odd;
  logic       overrun, overrun_odd;
  logic       busy, busy_odd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];
  logic [9:0] model_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_rx(rx_line),
    .o_data(data), .o_parity_err(perr), .o_frame_err(ferr),
    .o_valid(valid), .i_ready(ready), .o_count(count),
    .o_overrun(overrun), .i_clear_err(clear_err), .o_busy(busy)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut_odd (
    .i_clk(clk), .i_reset_n(rst_n), .i_rx(rx_line),
    .o_data(data_odd), .o_parity_err(perr_odd), .o_frame_err(ferr_odd),
    .o_valid(valid_odd), .i_ready(ready_odd), .o_count(count_odd),
    .o_overrun(overrun_odd), .i_clear_err(clear_err), .o_busy(busy_odd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: {data, parity_err, frame_err} computed from the frame contents.
  function automatic logic [9:0] expect_word(input logic [7:0] d, input logic pbit,
                                             input logic stop, input int mode);
    int  ones;
    logic pe;
    ones = $countones(d) + int'(pbit);
    pe   = (mode == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
    return {d, pe, ~stop};
  endfunction

  // Drives start, 8 data bits LSB first, parity, stop. abort_at > 0 stops
  // driving after that many cycles; low_after holds the line low afterwards.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input int low_after, input int abort_at);
    logic [10:0] bits;
    int cyc;
    bits = {stop, pbit, d, 1'b0};
    cyc  = 0;
    for (int i = 0; i < 11; i++) begin
      rx_line = bits[i];
      for (int c = 0; c < CPB; c++) begin
        if (abort_at > 0 && cyc == abort_at) return;
        tick(1);
        cyc++;
      end
    end
    if (low_after > 0) begin
      rx_line = 1'b0;
      tick(low_after);
    end
    rx_line = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic pop_one();
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic pop_and_check(input string name);
    logic [9:0] e;
    e = model_q.pop_front();
    check({name, "_valid"}, 32'(valid), 32'd1);
    check({name, "_word"}, 32'({data, perr, ferr}), 32'(e));
    pop_one();
  endtask

  initial begin
    logic [7:0] d;
    logic       pb, st;
    logic [9:0] w;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1};

    // Reset state
    tick(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(4);
    check("idle_busy", 32'(busy), 32'd0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].d, vecs[i].pbit, vecs[i].stop, 0, 0);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'd1);
      check($sformatf("vec%0d_count", i), 32'(count), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_perr", i), 32'(perr), 32'(vecs[i].exp_perr));
      check($sformatf("vec%0d_ferr", i), 32'(ferr), 32'(vecs[i].exp_ferr));
      pop_one();
      check($sformatf("vec%0d_empty", i), 32'(count), 32'd0);
    end

    // Same 0x3C frame with parity bit 1: odd-mode receiver sees it clean
    ready_odd = 1'b0;
    tick(2);
    send_frame(8'h3C, 1'b1, 1'b1, 0, 0);
    check("odd_valid", 32'(valid_odd), 32'd1);
    check("odd_word", 32'({data_odd, perr_odd, ferr_odd}), 32'({8'h3C, 1'b0, 1'b0}));
    check("even_perr", 32'(perr), 32'd1);
    pop_one();
    ready_odd = 1'b1;
    tick(2);

    // Pop when empty is ignored
    pop_one();
    check("empty_pop_count", 32'(count), 32'd0);
    check("empty_pop_valid", 32'(valid), 32'd0);

    // Short low glitch
    rx_line = 1'b0;
    tick(4);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    tick(1);
    rx_line = 1'b1;
    tick(10);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    check("glitch_count", 32'(count), 32'd0);

    // Bad stop bit followed by a held-low line: one word, no retrigger
    send_frame(8'h55, 1'b0, 1'b0, 40, 0);
    check("frm_count", 32'(count), 32'd1);
    check("frm_word", 32'({data, perr, ferr}), 32'({8'h55, 1'b0, 1'b1}));
    check("frm_busy", 32'(busy), 32'd0);
    pop_one();

    // Randomised frames against the model
    for (int n = 0; n < 20; n++) begin
      d  = 8'($urandom);
      pb = (^d) ^ ($urandom_range(3) == 0);
      st = ($urandom_range(4) != 0);
      send_frame(d, pb, st, 0, 0);
      model_q.push_back(expect_word(d, pb, st, 1));
      check($sformatf("rnd%0d_count", n), 32'(count), 32'(model_q.size()));
      if (model_q.size() == DEPTH || $urandom_range(1) == 1) begin
        while (model_q.size() > 0) pop_and_check($sformatf("rnd%0d_pop", n));
        check($sformatf("rnd%0d_drained", n), 32'(count), 32'd0);
      end
    end
    while (model_q.size() > 0) pop_and_check("rnd_tail");

    // Overrun: five frames with no reads
    for (int n = 0; n < 5; n++) begin
      d  = 8'($urandom);
      pb = ^d;
      send_frame(d, pb, 1'b1, 0, 0);
      w = expect_word(d, pb, 1'b1, 1);
      if (model_q.size() < DEPTH) model_q.push_back(w);
    end
    check("ovr_count", 32'(count), 32'd4);
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int k = 0; k < 4; k++) pop_and_check($sformatf("ovr_pop%0d", k));
    check("ovr_sticky", 32'(overrun), 32'd1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Reset in the middle of a frame
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
    check("pre_rst_valid", 32'(valid), 32'd1);
    send_frame(8'h81, 1'b0, 1'b1, 0, 3 * CPB);
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rx_line = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_busy", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1, 0, 0);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_word", 32'({data, perr, ferr}), 32'(expect_word(8'h81, 1'b0, 1'b1, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
